// File: rtl/cve2_obi_arbiter.sv
// Two-master OBI arbiter: merges instruction fetch and load/store ports onto a
// single memory port. Round-robin on ties, selection locked while a request
// waits for grant, in-order responses routed back via a source-ID FIFO.
module cve2_obi_arbiter #(
    parameter int unsigned  MaxOutstanding = 2,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            instr_req_i,
    output logic            instr_gnt_o,
    output logic            instr_rvalid_o,
    input  logic [31:0]     instr_addr_i,
    output logic [31:0]     instr_rdata_o,
    output logic            instr_err_o,

    input  logic            data_req_i,
    output logic            data_gnt_o,
    output logic            data_rvalid_o,
    input  logic            data_we_i,
    input  logic [3:0]      data_be_i,
    input  logic [31:0]     data_addr_i,
    input  logic [31:0]     data_wdata_i,
    output logic [31:0]     data_rdata_o,
    output logic            data_err_o,

    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    input  logic [31:0]     mem_rdata_i,
    input  logic            mem_err_i,

    output logic [CntW-1:0] outstanding_o,
    output logic            protocol_err_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {
        SEL_INSTR = 1'b0,
        SEL_DATA  = 1'b1
    } sel_e;

    sel_e            sel;
    sel_e            rr_last_q, rr_last_d;
    sel_e            lock_sel_q, lock_sel_d;
    sel_e            head;
    sel_e            fifo_q [MaxOutstanding];
    logic            lock_q, lock_d;
    logic            perr_q, perr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic            full, empty, push, pop;

    assign full  = (count_q == CntW'(MaxOutstanding));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rptr_q];

    // Pick the port to present: locked port first, then sole requester, then round-robin.
    always_comb begin
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (instr_req_i && !data_req_i) begin
            sel = SEL_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            sel = SEL_DATA;
        end else begin
            sel = (rr_last_q == SEL_INSTR) ? SEL_DATA : SEL_INSTR;
        end
    end

    // Request side: no new request is issued while the response FIFO is full.
    assign mem_req_o   = (instr_req_i | data_req_i) & ~full;
    assign mem_we_o    = (sel == SEL_DATA) ? data_we_i    : 1'b0;
    assign mem_be_o    = (sel == SEL_DATA) ? data_be_i    : 4'hF;
    assign mem_addr_o  = (sel == SEL_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = (sel == SEL_DATA) ? data_wdata_i : 32'h0;

    assign instr_gnt_o = mem_gnt_i & mem_req_o & (sel == SEL_INSTR);
    assign data_gnt_o  = mem_gnt_i & mem_req_o & (sel == SEL_DATA);

    // A response with nothing outstanding is not routed; it only flags an error.
    assign push = mem_req_o & mem_gnt_i;
    assign pop  = mem_rvalid_i & ~empty;

    assign instr_rvalid_o = pop & (head == SEL_INSTR);
    assign data_rvalid_o  = pop & (head == SEL_DATA);
    assign instr_err_o    = mem_err_i & instr_rvalid_o;
    assign data_err_o     = mem_err_i & data_rvalid_o;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign outstanding_o  = count_q;
    assign protocol_err_o = perr_q;

    // Next-state for counter, pointers, lock, round-robin and sticky error.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        lock_d     = mem_req_o & ~mem_gnt_i;
        lock_sel_d = lock_sel_q;
        rr_last_d  = rr_last_q;
        perr_d     = perr_q | (mem_rvalid_i & empty);

        if (lock_d) begin
            lock_sel_d = sel;
        end
        if (push) begin
            rr_last_d = sel;
            wptr_d    = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            lock_q     <= 1'b0;
            lock_sel_q <= SEL_INSTR;
            rr_last_q  <= SEL_INSTR;
            perr_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            rr_last_q  <= rr_last_d;
            perr_q     <= perr_d;
        end
    end

    // Source-ID storage, written at the tail on each accepted request.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; entries are only read while the counter says they are valid.
        if (push) begin
            fifo_q[wptr_q] <= sel;
        end
    end

endmodule
